// File: rtl/lvds_clk_pkg.sv
// Shared types and defaults for the forwarded sensor LVDS clock-enable sequencer.
package lvds_clk_pkg;

  localparam int STATE_W       = 2;
  localparam int PWRUP_DLY_DEF = 1024;
  localparam int MIN_OFF_DEF   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_PWRUP = 2'd0,
    ST_OFF   = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // A delay window shorter than one cycle still costs one full cycle.
  function automatic int eff_dly(input int dly);
    return (dly < 1) ? 1 : dly;
  endfunction

endpackage

// File: rtl/lvds_clk_dly_cnt.sv
// Loadable down-counter with zero flag; shared by the power-up and off-time windows.
module lvds_clk_dly_cnt #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Parks at zero so the owner can sample the flag for as long as it likes.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lvds_clk_ce_ctrl.sv
// Clock-enable sequencer for the ODDR2 forwarded sensor clock: power-up hold-off, start/stop, min off-time.
// Optional auto-stop burst mode enabled by defining LVDS_CLK_BURST_EN.
module lvds_clk_ce_ctrl
  import lvds_clk_pkg::*;
#(
  parameter int PWRUP_DLY = PWRUP_DLY_DEF,
  parameter int MIN_OFF   = MIN_OFF_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk_lvds_sdr_in,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             stop_req,
  input  logic [CNT_W-1:0] burst_len,
  output logic             ce,
  output logic             clk_on,
  output logic             ready,
  output logic             start_drop,
  output logic [CNT_W-1:0] run_cnt
);

  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(eff_dly(PWRUP_DLY) - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(eff_dly(MIN_OFF) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q;
  logic             ce_q, clk_on_q, ready_q, start_drop_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             start_ok, burst_done, stop_run;
  logic             dly_load, dly_en, dly_zero;

  assign start_ok  = (state_q == ST_OFF) && start_req && !stop_req;
  assign run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;

`ifdef LVDS_CLK_BURST_EN
  logic [CNT_W-1:0] burst_q;

  always_ff @(posedge clk_lvds_sdr_in or negedge rst_n) begin
    if (!rst_n)        burst_q <= '0;
    else if (start_ok) burst_q <= burst_len;
  end

  // Exit on the edge that completes the burst_q-th ce-high cycle.
  assign burst_done = (burst_q != '0) && (run_cnt_q == burst_q - 1'b1);
`else
  logic unused_burst_len;
  assign unused_burst_len = ^burst_len;
  assign burst_done       = 1'b0;
`endif

  assign stop_run = (state_q == ST_RUN) && (stop_req || burst_done);
  assign dly_load = stop_run;
  assign dly_en   = (state_q == ST_PWRUP) || (state_q == ST_HOLD);

  lvds_clk_dly_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (PWRUP_LD)
  ) u_dly (
    .clk_i      (clk_lvds_sdr_in),
    .rst_ni     (rst_n),
    .load_i     (dly_load),
    .en_i       (dly_en),
    .load_val_i (HOLD_LD),
    .zero_o     (dly_zero)
  );

  // Outputs are set on the same edge as the state change so ce is a clean flop into ODDR2 CE.
  always_ff @(posedge clk_lvds_sdr_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PWRUP;
      ce_q         <= 1'b0;
      clk_on_q     <= 1'b0;
      ready_q      <= 1'b0;
      start_drop_q <= 1'b0;
      run_cnt_q    <= '0;
    end else begin
      start_drop_q <= start_req && (state_q != ST_OFF);
      unique case (state_q)
        ST_PWRUP: begin
          if (dly_zero) begin
            state_q <= ST_OFF;
            ready_q <= 1'b1;
          end
        end
        ST_OFF: begin
          if (start_ok) begin
            state_q   <= ST_RUN;
            ce_q      <= 1'b1;
            clk_on_q  <= 1'b1;
            ready_q   <= 1'b0;
            run_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          run_cnt_q <= run_cnt_d;
          if (stop_run) begin
            state_q  <= ST_HOLD;
            ce_q     <= 1'b0;
            clk_on_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (dly_zero) begin
            state_q <= ST_OFF;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  assign ce         = ce_q;
  assign clk_on     = clk_on_q;
  assign ready      = ready_q;
  assign start_drop = start_drop_q;
  assign run_cnt    = run_cnt_q;

endmodule

// File: tb/tb_lvds_clk_ce_ctrl.sv
// Bench for lvds_clk_ce_ctrl: timeline model per instance, compared every cycle, plus pinned literals.
module tb_lvds_clk_ce_ctrl;

  localparam int PW_B = 1024, MO_B = 16, W_B = 16;
  localparam int PW_S = 0,    MO_S = 0,  W_S = 4;
`ifdef LVDS_CLK_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           b_start = 1'b0, b_stop = 1'b0;
  logic [W_B-1:0] b_len = '0;
  logic           b_ce, b_on, b_rdy, b_drop;
  logic [W_B-1:0] b_cnt;
  logic           s_start = 1'b0, s_stop = 1'b0;
  logic [W_S-1:0] s_len = '0;
  logic           s_ce, s_on, s_rdy, s_drop;
  logic [W_S-1:0] s_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  lvds_clk_ce_ctrl #(.PWRUP_DLY(PW_B), .MIN_OFF(MO_B), .CNT_W(W_B)) u_big (
    .clk_lvds_sdr_in(clk), .rst_n(rst_n), .start_req(b_start), .stop_req(b_stop),
    .burst_len(b_len), .ce(b_ce), .clk_on(b_on), .ready(b_rdy), .start_drop(b_drop), .run_cnt(b_cnt));

  lvds_clk_ce_ctrl #(.PWRUP_DLY(PW_S), .MIN_OFF(MO_S), .CNT_W(W_S)) u_small (
    .clk_lvds_sdr_in(clk), .rst_n(rst_n), .start_req(s_start), .stop_req(s_stop),
    .burst_len(s_len), .ce(s_ce), .clk_on(s_on), .ready(s_rdy), .start_drop(s_drop), .run_cnt(s_cnt));

  // Timeline model: t counts edges since reset release; starts are legal once t reaches off_from.
  typedef struct {
    int t; int off_from; bit running; int runcnt; int burst; bit ready; bit drop;
  } mdl_t;

  function automatic mdl_t m_reset(input int pw);
    mdl_t m;
    m.t = 0; m.off_from = (pw < 1) ? 1 : pw; m.running = 0;
    m.runcnt = 0; m.burst = 0; m.ready = 0; m.drop = 0;
    return m;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input bit s, input bit p, input int bl, input int mo);
    mdl_t n;
    n = m;
    n.t = m.t + 1;
    n.drop = s && !m.ready;
    if (m.running) begin
      n.runcnt = m.runcnt + 1;
      if (p || (BURST_EN && m.burst != 0 && n.runcnt == m.burst)) begin
        n.running = 0;
        n.off_from = n.t + ((mo < 1) ? 1 : mo);
      end
    end else if (m.ready && s && !p) begin
      n.running = 1; n.runcnt = 0; n.burst = bl;
    end
    n.ready = !n.running && (n.t >= n.off_from);
    return n;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  mdl_t mb, ms;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb <= m_reset(PW_B);
      ms <= m_reset(PW_S);
    end else begin
      mb <= m_step(mb, b_start, b_stop, int'(b_len), MO_B);
      ms <= m_step(ms, s_start, s_stop, int'(s_len), MO_S);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_ce",   int'(b_ce),   int'(mb.running));
      chk("b_on",   int'(b_on),   int'(mb.running));
      chk("b_rdy",  int'(b_rdy),  int'(mb.ready));
      chk("b_drop", int'(b_drop), int'(mb.drop));
      chk("b_cnt",  int'(b_cnt),  sat(mb.runcnt, W_B));
      chk("s_ce",   int'(s_ce),   int'(ms.running));
      chk("s_on",   int'(s_on),   int'(ms.running));
      chk("s_rdy",  int'(s_rdy),  int'(ms.ready));
      chk("s_drop", int'(s_drop), int'(ms.drop));
      chk("s_cnt",  int'(s_cnt),  sat(ms.runcnt, W_S));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_ce",   int'(b_ce),   0);
    chk("rst_rdy",  int'(b_rdy),  0);
    chk("rst_drop", int'(b_drop), 0);
    chk("rst_on",   int'(b_on),   0);
    chk("rst_cnt",  int'(b_cnt),  0);
    #1 rst_n = 1'b1;
    fork
      begin
        tick(4);
        b_start = 1; tick(1); b_start = 0;            // edge 5, still powering up
        chk("pwrup_drop", int'(b_drop), 1);
        chk("pwrup_ce",   int'(b_ce),   0);
        tick(1018);
        chk("pwrup_rdy_1023", int'(b_rdy), 0);
        tick(1);
        chk("pwrup_rdy_1024", int'(b_rdy), 1);
        b_stop = 1; tick(1); b_stop = 0;
        chk("off_stop_rdy", int'(b_rdy), 1);
        b_start = 1; tick(1); b_start = 0;
        chk("start_ce",  int'(b_ce),  1);
        chk("start_cnt", int'(b_cnt), 0);
        tick(3);
        b_start = 1; tick(1); b_start = 0;
        chk("run_drop", int'(b_drop), 1);
        chk("run_ce",   int'(b_ce),   1);
        tick(95);
        b_stop = 1; tick(1); b_stop = 0;
        chk("stop_ce",  int'(b_ce),  0);
        chk("stop_cnt", int'(b_cnt), 100);
        tick(2);
        b_start = 1; tick(1); b_start = 0;
        chk("hold_drop", int'(b_drop), 1);
        chk("hold_ce",   int'(b_ce),   0);
        tick(12);
        chk("hold_rdy_15", int'(b_rdy), 0);
        tick(1);
        chk("hold_rdy_16", int'(b_rdy), 1);
        chk("hold_cnt_kept", int'(b_cnt), 100);
        b_start = 1; tick(1); b_start = 0;
        chk("restart_cnt", int'(b_cnt), 0);
        tick(5);
        b_stop = 1; tick(1); b_stop = 0;
        chk("short_cnt", int'(b_cnt), 6);
        tick(16);
        b_start = 1; b_stop = 1; tick(1); b_start = 0; b_stop = 0;
        chk("both_ce",   int'(b_ce),   0);
        chk("both_drop", int'(b_drop), 0);
        chk("both_rdy",  int'(b_rdy),  1);
`ifdef LVDS_CLK_BURST_EN
        b_len = 8; b_start = 1; tick(1); b_start = 0;
        tick(7);
        chk("burst8_ce_7", int'(b_ce), 1);
        tick(1);
        chk("burst8_ce_8", int'(b_ce), 0);
        chk("burst8_cnt",  int'(b_cnt), 8);
        tick(16);
        b_len = 0; b_start = 1; tick(1); b_start = 0;
        tick(40);
        chk("cont_ce", int'(b_ce), 1);
        b_stop = 1; tick(1); b_stop = 0;
        chk("cont_cnt", int'(b_cnt), 41);
        tick(16);
        b_len = 50; b_start = 1; tick(1); b_start = 0;
        tick(9);
        b_stop = 1; tick(1); b_stop = 0;
        chk("early_cnt", int'(b_cnt), 10);
        tick(16);
        b_len = 5; b_start = 1; tick(1); b_start = 0;
        tick(4);
        b_stop = 1; tick(1); b_stop = 0;
        chk("coinc_ce",  int'(b_ce),  0);
        chk("coinc_cnt", int'(b_cnt), 5);
        tick(16);
        chk("coinc_rdy", int'(b_rdy), 1);
`endif
      end
      begin
        tick(1);
        chk("s_pwrup_rdy", int'(s_rdy), 1);
        s_start = 1; tick(1); s_start = 0;
        chk("s_start_cnt", int'(s_cnt), 0);
        tick(14);
        chk("s_cnt_14", int'(s_cnt), 14);
        tick(5);
        chk("s_cnt_sat", int'(s_cnt), 15);
        s_stop = 1; tick(1); s_stop = 0;
        chk("s_stop_cnt", int'(s_cnt), 15);
        chk("s_stop_rdy", int'(s_rdy), 0);
        tick(1);
        chk("s_hold1_rdy", int'(s_rdy), 1);
        s_start = 1; tick(1); s_start = 0;
        s_stop = 1; tick(1); s_stop = 0;
        chk("s_one_cnt", int'(s_cnt), 1);
        chk("s_one_ce",  int'(s_ce),  0);
        tick(1);
      end
    join
    b_len = 0;
    b_start = 1; tick(1); b_start = 0;
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ce", int'(b_ce), 0);
    chk("async_on", int'(b_on), 0);
    tick(2);
    #1 rst_n = 1'b1;
    tick(1023);
    chk("rerun_rdy_1023", int'(b_rdy), 0);
    tick(1);
    chk("rerun_rdy_1024", int'(b_rdy), 1);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
